pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage core (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_ctrl_pkg.sv | 39 +++
 rtl/pipeline_ctrl_if.sv | 35 +++
 rtl/pipeline_ctrl_sat_counter.sv | 36 +++
 rtl/pipeline_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
//   pc_state_e   : sequencer FSM state (also exposed on the debug port)
//   stage_ctl_t  : bundle of per-stage enable/bubble controls
//   CTL_*        : the fixed control patterns the sequencer selects between
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_BOOT  = 2'd0,
        PC_RUN   = 2'd1,
        PC_DRAIN = 2'd2
    } pc_state_e;

    // Bit order (MSB..LSB) matches the field order below.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_bubble;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic mem_wb_bubble;
    } stage_ctl_t;

    // Held while rst_n is low: nothing loads, everything reads as a NOP.
    localparam stage_ctl_t CTL_RESET  = 7'b0010101;
    // Boot: registers load NOPs while the PC stays put.
    localparam stage_ctl_t CTL_BOOT   = 7'b0111111;
    // Normal flow.
    localparam stage_ctl_t CTL_RUN    = 7'b1101010;
    // Data memory busy: freeze everything up to MEM, send a NOP into WB.
    localparam stage_ctl_t CTL_FREEZE = 7'b0000001;
    // Taken branch/jump: redirect PC, squash the two younger instructions.
    localparam stage_ctl_t CTL_CFLUSH = 7'b1111110;
    // Load-use: hold PC and IF/ID, insert one bubble into EX.
    localparam stage_ctl_t CTL_DFLUSH = 7'b0001110;
    // Fetch not available (or being discarded): hold PC, bubble into ID.
    localparam stage_ctl_t CTL_IMISS  = 7'b0111010;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake/control bundle between the sequencer and the pipeline datapath.
//   master : the sequencer (takes hazard/wait inputs, drives enables/bubbles
//            and the perf counters)
//   slave  : the datapath side
// Handshake: imem_valid is the fetch "valid"; pc_en is its "ready". A fetch
// is consumed only in a cycle where imem_valid=1 and pc_en=1; otherwise the
// imem keeps presenting the same PC. dmem_busy is a plain wait: while it is
// high, no stage before MEM/WB advances.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
    logic             data_flush;
    logic             ctrl_flush;
    logic             imem_valid;
    logic             dmem_busy;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_bubble;
    logic             id_ex_en;
    logic             id_ex_bubble;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  data_flush, ctrl_flush, imem_valid, dmem_busy,
        output pc_en, if_id_en, if_id_bubble, id_ex_en, id_ex_bubble,
               ex_mem_en, mem_wb_bubble, stall_cnt, flush_cnt
    );

    modport slave (
        output data_flush, ctrl_flush, imem_valid, dmem_busy,
        input  pc_en, if_id_en, if_id_bubble, id_ex_en, id_ex_bubble,
               ex_mem_en, mem_wb_bubble, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush perf counters.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   inc_i      : add one this cycle (ignored once at all-ones)
//   clr_i      : synchronous clear, wins over inc_i
//   q_o        : current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core.
//   clk, rst_n : clock, async active-low reset
//   bus        : pipeline_ctrl_if.master (hazard/wait inputs in, per-stage
//                enables/bubbles and perf counters out)
//   state_o    : current FSM state, for debug/observation
// Enables and bubbles are combinational from state and inputs so a stall
// takes effect in the cycle its cause is seen.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_ctrl_if.master   bus,
    output pc_state_e         state_o
);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    pc_state_e   state_q, state_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    stage_ctl_t  ctl;
    logic        stall_inc;
    logic        flush_inc;

    always_comb begin
        ctl        = CTL_BOOT;
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        flush_inc  = 1'b0;
        case (state_q)
            PC_BOOT: begin
                ctl = CTL_BOOT;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = PC_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BW'(1);
                end
            end
            PC_RUN: begin
                // EX is frozen under dmem_busy, so any flush request simply
                // re-presents once the memory access completes.
                if (bus.dmem_busy) begin
                    ctl = CTL_FREEZE;
                end else if (bus.ctrl_flush) begin
                    ctl       = CTL_CFLUSH;
                    flush_inc = 1'b1;
                    // The fetch for the wrong-path PC has not returned yet;
                    // remember to throw it away when it does.
                    if (!bus.imem_valid) begin
                        state_d = PC_DRAIN;
                    end
                end else if (bus.data_flush) begin
                    ctl = CTL_DFLUSH;
                end else if (!bus.imem_valid) begin
                    ctl = CTL_IMISS;
                end else begin
                    ctl = CTL_RUN;
                end
            end
            PC_DRAIN: begin
                // ID/EX holds bubbles here, so neither flush can be live.
                if (bus.dmem_busy) begin
                    ctl = CTL_FREEZE;
                end else begin
                    ctl = CTL_IMISS;
                    if (bus.imem_valid) begin
                        state_d = PC_RUN;
                    end
                end
            end
            default: begin
                state_d = PC_BOOT;
            end
        endcase
        // Outputs must show reset values as soon as rst_n falls, not at the
        // next clock edge.
        if (!rst_n) begin
            ctl = CTL_RESET;
        end
    end

    assign stall_inc = (state_q != PC_BOOT) && !ctl.pc_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PC_BOOT;
            boot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_inc),
        .clr_i (1'b0),
        .q_o   (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (flush_inc),
        .clr_i (1'b0),
        .q_o   (bus.flush_cnt)
    );

    assign bus.pc_en         = ctl.pc_en;
    assign bus.if_id_en      = ctl.if_id_en;
    assign bus.if_id_bubble  = ctl.if_id_bubble;
    assign bus.id_ex_en      = ctl.id_ex_en;
    assign bus.id_ex_bubble  = ctl.id_ex_bubble;
    assign bus.ex_mem_en     = ctl.ex_mem_en;
    assign bus.mem_wb_bubble = ctl.mem_wb_bubble;
    assign state_o           = state_q;
endmodule
